// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle sequencer.
// Holds the FSM/op enums, instruction field constants and the ALU-setup helper.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_LW,
        OP_BNE,
        OP_ILL
    } op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] ALUCTRL_ADD = 3'b000;
    localparam logic [2:0] ALUCTRL_SUB = 3'b001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       reg_write;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic [1:0] imm_src;
        logic       result_src;
        logic       pc_src;
        logic       pc_write;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // ALU operand/operation setup for an op; reused in every state that needs the ALU result stable.
    function automatic ctrl_t alu_setup(op_t op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_ADD: c.alu_ctrl = ALUCTRL_ADD;
            OP_SUB: c.alu_ctrl = ALUCTRL_SUB;
            OP_ADDI, OP_LW: begin
                c.alu_ctrl = ALUCTRL_ADD;
                c.alu_src  = 1'b1;
                c.imm_src  = IMM_I;
            end
            OP_BNE: begin
                c.alu_ctrl = ALUCTRL_SUB;
                c.imm_src  = IMM_B;
            end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational instruction classifier: opcode/funct fields of the IR -> op_t.
// Anything outside the supported subset maps to OP_ILL.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output op_t        op
);

    // NOTE: op gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        op = OP_ILL;
        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    op = OP_ADD;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    op = OP_SUB;
                end
            end
            OPC_OP_IMM: if (funct3 == F3_ADD) op = OP_ADDI;
            OPC_LOAD:   if (funct3 == F3_LW)  op = OP_LW;
            OPC_BRANCH: if (funct3 == F3_BNE) op = OP_BNE;
            default:    op = OP_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch over a req/valid port, IR/op registers,
// memory-stall watchdog and state/IR-decoded datapath controls.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  imem_req,
    input  logic                  imem_valid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  dmem_req,
    input  logic                  dmem_valid,
    input  logic                  EQ,
    output logic [DATA_WIDTH-1:0] instr_q,
    output logic                  RegWrite,
    output logic [2:0]            ALUctrl,
    output logic                  ALUsrc,
    output logic [1:0]            ImmSrc,
    output logic                  ResultSrc,
    output logic                  PCsrc,
    output logic                  PCwrite,
    output logic                  retire,
    output logic                  illegal,
    output logic                  err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t          state;
    state_t          state_next;
    op_t             op_q;
    op_t             dec_op;
    ctrl_t           ctrl;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_inc;
    logic            timeout;
    logic            err_q;

    instr_decode u_decode (
        .opcode (instr_q[6:0]),
        .funct3 (instr_q[14:12]),
        .funct7 (instr_q[31:25]),
        .op     (dec_op)
    );

    assign wait_inc = wait_cnt + CW'(1);
    assign timeout  = (wait_inc == CW'(MAX_WAIT));

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            instr_q  <= '0;
            op_q     <= OP_ILL;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
            state <= state_next;
            if (state == FETCH && imem_valid) begin
                instr_q <= imem_rdata;
            end
            if (state == DECODE) begin
                op_q <= dec_op;
            end
            // Counter runs only while a request is outstanding; any other state clears it.
            if ((state == FETCH && !imem_valid) || (state == MEM && !dmem_valid)) begin
                wait_cnt <= wait_inc;
            end else begin
                wait_cnt <= '0;
            end
            if (state_next == HALT) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        ctrl       = CTRL_NONE;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                ctrl.imem_req = 1'b1;
                if (imem_valid) begin
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = HALT;
                end
            end
            DECODE: begin
                if (dec_op == OP_ILL) begin
                    ctrl.illegal  = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = run ? FETCH : IDLE;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                ctrl = alu_setup(op_q);
                case (op_q)
                    OP_BNE: begin
                        ctrl.pc_src   = ~EQ;
                        ctrl.pc_write = 1'b1;
                        ctrl.retire   = 1'b1;
                        state_next    = run ? FETCH : IDLE;
                    end
                    OP_LW:   state_next = MEM;
                    default: state_next = WRITEBACK;
                endcase
            end
            MEM: begin
                ctrl          = alu_setup(op_q);
                ctrl.dmem_req = 1'b1;
                if (dmem_valid) begin
                    state_next = WRITEBACK;
                end else if (timeout) begin
                    state_next = HALT;
                end
            end
            WRITEBACK: begin
                // ALU setup is held so the combinational result being written stays valid.
                ctrl            = alu_setup(op_q);
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = (op_q == OP_LW);
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = 1'b0;
                ctrl.retire     = 1'b1;
                state_next      = run ? FETCH : IDLE;
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
        if (rst) begin
            ctrl = CTRL_NONE;
        end
    end

    assign imem_req  = ctrl.imem_req;
    assign dmem_req  = ctrl.dmem_req;
    assign RegWrite  = ctrl.reg_write;
    assign ALUctrl   = ctrl.alu_ctrl;
    assign ALUsrc    = ctrl.alu_src;
    assign ImmSrc    = ctrl.imm_src;
    assign ResultSrc = ctrl.result_src;
    assign PCsrc     = ctrl.pc_src;
    assign PCwrite   = ctrl.pc_write;
    assign retire    = ctrl.retire;
    assign illegal   = ctrl.illegal;
    assign err       = err_q & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each instruction class,
// watchdog limit behaviour and reset in the middle of an instruction.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_valid;
    logic        EQ;
    logic [31:0] instr_q;
    logic        RegWrite;
    logic [2:0]  ALUctrl;
    logic        ALUsrc;
    logic [1:0]  ImmSrc;
    logic        ResultSrc;
    logic        PCsrc;
    logic        PCwrite;
    logic        retire;
    logic        illegal;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Control vector bit masks: {imem_req,dmem_req,RegWrite,ALUctrl[2:0],ALUsrc,ImmSrc[1:0],
    // ResultSrc,PCsrc,PCwrite,retire,illegal,err}
    localparam logic [14:0] IREQ  = 15'h4000;
    localparam logic [14:0] DREQ  = 15'h2000;
    localparam logic [14:0] RW    = 15'h1000;
    localparam logic [14:0] ASUB  = 15'h0200;
    localparam logic [14:0] ASRC  = 15'h0100;
    localparam logic [14:0] IMMB  = 15'h0080;
    localparam logic [14:0] RSRC  = 15'h0020;
    localparam logic [14:0] PCSRC = 15'h0010;
    localparam logic [14:0] PCW   = 15'h0008;
    localparam logic [14:0] RET   = 15'h0004;
    localparam logic [14:0] ILL   = 15'h0002;
    localparam logic [14:0] ERR   = 15'h0001;
    localparam logic [14:0] NONE  = 15'h0000;
    localparam logic [14:0] MF    = 15'h7FFF;
    localparam logic [14:0] MW    = 15'h703F;  // ALU setup fields are don't-care in writeback

    multicycle_ctrl #(.DATA_WIDTH(32), .MAX_WAIT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_valid (dmem_valid),
        .EQ         (EQ),
        .instr_q    (instr_q),
        .RegWrite   (RegWrite),
        .ALUctrl    (ALUctrl),
        .ALUsrc     (ALUsrc),
        .ImmSrc     (ImmSrc),
        .ResultSrc  (ResultSrc),
        .PCsrc      (PCsrc),
        .PCwrite    (PCwrite),
        .retire     (retire),
        .illegal    (illegal),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ctl();
        return {imem_req, dmem_req, RegWrite, ALUctrl, ALUsrc, ImmSrc,
                ResultSrc, PCsrc, PCwrite, retire, illegal, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles from the current state, pulsing imem_valid at cycle iv_at and dmem_valid
    // at cycle dv_at (-1 = never), and records the settled control vector of each cycle.
    task automatic drive_seq(input int iv_at, input logic [31:0] word, input int dv_at,
                             input int n, output logic [14:0] obs[$]);
        obs = {};
        for (int k = 0; k < n; k++) begin
            imem_valid = (k == iv_at);
            imem_rdata = (k == iv_at) ? word : 32'hdeadbeef;
            dmem_valid = (k == dv_at);
            #1;
            obs.push_back(ctl());
            @(posedge clk);
            #1;
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        tick();
        tick();
        total++;
        if (ctl() !== NONE) begin
            bad++;
            $display("FAIL reset_ctl: got %h want %h", ctl(), NONE);
        end
        total++;
        if (instr_q !== 32'h0) begin
            bad++;
            $display("FAIL reset_ir: got %h want %h", instr_q, 32'h0);
        end
        rst = 1'b0;
        tick();
        tick();
        total++;
        if (ctl() !== NONE) begin
            bad++;
            $display("FAIL idle_ctl: got %h want %h", ctl(), NONE);
        end
    endtask

    task automatic test_addi();
        logic [14:0] o[$];
        logic [14:0] e[$];
        logic [14:0] m[$];
        run = 1'b1;
        tick();
        e = '{IREQ, NONE, ASRC, RW | PCW | RET};
        m = '{MF, MF, MF, MW};
        drive_seq(0, 32'h00500093, -1, 4, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if ((o[k] & m[k]) !== (e[k] & m[k])) begin
                bad++;
                $display("FAIL addi_c%0d: got %h want %h", k, o[k] & m[k], e[k] & m[k]);
            end
        end
        total++;
        if (instr_q !== 32'h00500093) begin
            bad++;
            $display("FAIL addi_ir: got %h want %h", instr_q, 32'h00500093);
        end
        #1;
        total++;
        if (ctl() !== IREQ) begin
            bad++;
            $display("FAIL addi_refetch: got %h want %h", ctl(), IREQ);
        end
    endtask

    task automatic test_add_sub();
        logic [14:0] o[$];
        logic [14:0] e[$];
        logic [14:0] m[$];
        m = '{MF, MF, MF, MW};
        e = '{IREQ, NONE, NONE, RW | PCW | RET};
        drive_seq(0, 32'h002081b3, -1, 4, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if ((o[k] & m[k]) !== (e[k] & m[k])) begin
                bad++;
                $display("FAIL add_c%0d: got %h want %h", k, o[k] & m[k], e[k] & m[k]);
            end
        end
        e = '{IREQ, NONE, ASUB, RW | PCW | RET};
        drive_seq(0, 32'h402081b3, -1, 4, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if ((o[k] & m[k]) !== (e[k] & m[k])) begin
                bad++;
                $display("FAIL sub_c%0d: got %h want %h", k, o[k] & m[k], e[k] & m[k]);
            end
        end
    endtask

    task automatic test_bne();
        logic [14:0] o[$];
        logic [14:0] e[$];
        EQ = 1'b0;
        e = '{IREQ, NONE, ASUB | IMMB | PCSRC | PCW | RET};
        drive_seq(0, 32'hfe009ee3, -1, 3, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if (o[k] !== e[k]) begin
                bad++;
                $display("FAIL bne_taken_c%0d: got %h want %h", k, o[k], e[k]);
            end
        end
        EQ = 1'b1;
        e = '{IREQ, IREQ, NONE, ASUB | IMMB | PCW | RET};
        drive_seq(1, 32'hfe009ee3, -1, 4, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if (o[k] !== e[k]) begin
                bad++;
                $display("FAIL bne_fall_c%0d: got %h want %h", k, o[k], e[k]);
            end
        end
        EQ = 1'b0;
    endtask

    task automatic test_lw();
        logic [14:0] o[$];
        logic [14:0] e[$];
        logic [14:0] m[$];
        e = '{IREQ, NONE, ASRC, DREQ | ASRC, DREQ | ASRC, DREQ | ASRC, RW | RSRC | PCW | RET};
        m = '{MF, MF, MF, MF, MF, MF, MW};
        drive_seq(0, 32'h0000a103, 5, 7, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if ((o[k] & m[k]) !== (e[k] & m[k])) begin
                bad++;
                $display("FAIL lw_c%0d: got %h want %h", k, o[k] & m[k], e[k] & m[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [14:0] o[$];
        logic [14:0] e[$];
        e = '{IREQ, ILL | PCW, IREQ};
        drive_seq(0, 32'hffffffff, -1, 3, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if (o[k] !== e[k]) begin
                bad++;
                $display("FAIL illegal_c%0d: got %h want %h", k, o[k], e[k]);
            end
        end
    endtask

    task automatic test_run_stop();
        logic [14:0] o[$];
        logic [14:0] e[$];
        logic [14:0] m[$];
        run = 1'b0;
        e = '{IREQ, NONE, ASRC, RW | PCW | RET, NONE, NONE};
        m = '{MF, MF, MF, MW, MF, MF};
        drive_seq(0, 32'h00500093, -1, 6, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if ((o[k] & m[k]) !== (e[k] & m[k])) begin
                bad++;
                $display("FAIL runstop_c%0d: got %h want %h", k, o[k] & m[k], e[k] & m[k]);
            end
        end
    endtask

    task automatic test_valid_at_limit();
        logic [14:0] o[$];
        logic [14:0] e[$];
        logic [14:0] m[$];
        run = 1'b1;
        tick();
        e = {};
        m = {};
        for (int k = 0; k < 16; k++) begin
            e.push_back(IREQ);
            m.push_back(MF);
        end
        e.push_back(NONE);
        m.push_back(MF);
        e.push_back(ASRC);
        m.push_back(MF);
        e.push_back(RW | PCW | RET);
        m.push_back(MW);
        drive_seq(15, 32'h00500093, -1, 19, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if ((o[k] & m[k]) !== (e[k] & m[k])) begin
                bad++;
                $display("FAIL limit_c%0d: got %h want %h", k, o[k] & m[k], e[k] & m[k]);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [14:0] o[$];
        logic [14:0] e[$];
        e = {};
        for (int k = 0; k < 16; k++) e.push_back(IREQ);
        e.push_back(ERR);
        e.push_back(ERR);
        e.push_back(ERR);
        drive_seq(-1, 32'h0, -1, 19, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if (o[k] !== e[k]) begin
                bad++;
                $display("FAIL watchdog_c%0d: got %h want %h", k, o[k], e[k]);
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if (ctl() !== NONE) begin
            bad++;
            $display("FAIL halt_in_rst: got %h want %h", ctl(), NONE);
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (ctl() !== NONE) begin
            bad++;
            $display("FAIL halt_exit: got %h want %h", ctl(), NONE);
        end
        tick();
        total++;
        if (ctl() !== IREQ) begin
            bad++;
            $display("FAIL restart_fetch: got %h want %h", ctl(), IREQ);
        end
    endtask

    task automatic test_reset_in_mem();
        logic [14:0] o[$];
        logic [14:0] e[$];
        e = '{IREQ, NONE, ASRC, DREQ | ASRC, DREQ | ASRC};
        drive_seq(0, 32'h0000a103, -1, 5, o);
        for (int k = 0; k < e.size(); k++) begin
            total++;
            if (o[k] !== e[k]) begin
                bad++;
                $display("FAIL rstmem_c%0d: got %h want %h", k, o[k], e[k]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b0;
        #1;
        total++;
        if (ctl() !== NONE) begin
            bad++;
            $display("FAIL rstmem_ctl: got %h want %h", ctl(), NONE);
        end
        total++;
        if (instr_q !== 32'h0) begin
            bad++;
            $display("FAIL rstmem_ir: got %h want %h", instr_q, 32'h0);
        end
        tick();
        total++;
        if (ctl() !== NONE) begin
            bad++;
            $display("FAIL rstmem_idle: got %h want %h", ctl(), NONE);
        end
    endtask

    initial begin
        rst        = 1'b1;
        run        = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        dmem_valid = 1'b0;
        EQ         = 1'b0;
        #1;
        test_reset();
        test_addi();
        test_add_sub();
        test_bne();
        test_lw();
        test_illegal();
        test_run_stop();
        test_valid_at_limit();
        test_watchdog();
        test_reset_in_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
